phy_tx_serializer: RTL
======================

# phy_tx_serializer

Lane serializer sitting directly downstream of the TX PHY manager: captures each 8b/10b-encoded flit on the manager's `start_out` strobe, trims it to the symbol count given by `comma_length_sel_out`, and shifts the valid symbols out across `NLANES` serial lanes. It returns a one-cycle `done` pulse per flit, which drives the manager's `done` input and advances the arbitration buffer. It supports back-to-back flits with no bubble.

## Interface
- `NLANES`, default 1: bits emitted per cycle; legal values 1, 2, 4, 8, 10.
- `CLK`  in  1  system clock.
- `nRST`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle strobe; `enc_flit` and `comma_length_sel` are valid this cycle.
- `enc_flit`  in  80  eight 10-bit symbols; symbol k is at `[10k+9:10k]`.
- `comma_length_sel`  in  2  symbol count: `SEL_COMMA_1`=2'b00 (1 symbol), `SEL_COMMA_2`=2'b01 (2 symbols), `SEL_DATA`=2'b10 (8 symbols); 2'b11 is illegal.
- `serial_out`  out  NLANES  current beat; lane 0 carries the earliest bit.
- `serial_valid`  out  1  a beat is being driven.
- `done`  out  1  one-cycle pulse coincident with a flit's last beat.
- `busy`  out  1  a flit is in flight.
- `overrun`  out  1  sticky; `start` arrived while the block could not accept it.
- `illegal_sel`  out  1  sticky; 2'b11 was seen on an accepted `start`.

## Operation
- The bit stream is symbol 0 first and, within each symbol, bit 0 first (8b/10b bit a). Length is `nbits` = 10 × nsym.
- Beats per flit = ceil(`nbits`/`NLANES`). Pad lanes of the last beat are driven 0.
- FSM has two states.
  - IDLE: `start` → load shift register with `enc_flit`, load `beats_left`, go to SHIFT.
  - SHIFT: each cycle, drive `serial_out` from the low `NLANES` bits, shift right by `NLANES`, decrement `beats_left`.
  - SHIFT on the last beat (`beats_left`==1): assert `done`. If `start` is high the same cycle, reload and stay in SHIFT. Otherwise go to IDLE.
- Acceptance: `start` is accepted in IDLE or on the last-beat cycle. `start` on any other SHIFT cycle is dropped, `overrun` is set, and the current flit is unaffected.
- An illegal `comma_length_sel` is sent as 8 symbols and sets `illegal_sel`.
- `beats_left` width is $clog2(80+1) = 7 bits. The computation is `(nbits + NLANES - 1) / NLANES`, elaborated as a 3-entry constant lookup; there is no runtime divider.
- Sticky flags clear only on reset.
- Reset, including mid-flit: all state is cleared immediately and the flit is discarded. No `done` is issued for it.

## Timing
- Reset values: `serial_out`=0, `serial_valid`=0, `done`=0, `busy`=0, `overrun`=0, `illegal_sel`=0, FSM=IDLE.
- Latency: `start` at cycle t gives the first beat at t+1 (registered outputs).
- A flit of B beats occupies cycles t+1 … t+B; `done` is high at t+B.
- `busy` = `serial_valid`, high t+1 … t+B.
- Back-to-back: `start` at t+B gives the next flit's first beat at t+B+1, so there is no idle cycle.
- `done` never stays high for two consecutive cycles unless B=1 and flits arrive back-to-back.

## Structure
- The `comma_length_sel` encodings `SEL_COMMA_1`, `SEL_COMMA_2` and `SEL_DATA` live in `phy_types_pkg` as `comma_length_sel_t`, shared with the encoder wrapper.
- Symbol width (10) and max symbols (8) are also `phy_types_pkg` localparams.
- Single module with no sub-modules. The beat-count lookup is a function in the package, `beats_for_sel(sel, NLANES)`.

## Test plan
- NLANES=1, `SEL_COMMA_1`, `enc_flit[9:0]`=10'h17C, `start`@t:
  - `serial_out` = 0,0,1,1,1,1,1,0,1,0 on t+1…t+10.
  - `done`@t+10; `busy` low at t+11.
- NLANES=4, `SEL_COMMA_2`, symbols 10'h17C, 10'h283:
  - 5 beats: 4'hC, 4'h7, 4'hD, 4'h0, 4'hA; all 20 bits valid, so no pad.
  - `done` on the 5th beat.
- NLANES=8, `SEL_COMMA_1`, symbol 10'h3FF:
  - 2 beats: 8'hFF, then 8'h03 with the upper 6 bits padded 0.
- NLANES=10, back-to-back `SEL_DATA` flits with `start` on each `done` cycle:
  - 16 contiguous valid beats.
  - `done` at beats 8 and 16; no gap.
  - `overrun` stays 0.
- NLANES=2, `start` at the 3rd beat of a data flit:
  - `overrun`=1.
  - The original 40 beats are unchanged; the dropped flit is never emitted.
- Mid-flit and illegal select:
  - `nRST` low at beat 30 of 80: all outputs are 0 asynchronously; after release, IDLE and no `done`.
  - Then `comma_length_sel`=2'b11: 80/NLANES beats are sent and `illegal_sel`=1.

Source files
------------

// File: rtl/phy_types_pkg.sv
// Shared PHY types: comma/data length select encodings, symbol geometry and
// the beat-count helper used to size serializer flits.
package phy_types_pkg;

  localparam int SYM_W    = 10;
  localparam int MAX_SYMS = 8;
  localparam int FLIT_W   = SYM_W * MAX_SYMS;
  localparam int BEATS_W  = $clog2(FLIT_W + 1);

  typedef enum logic [1:0] {
    SEL_COMMA_1 = 2'b00,
    SEL_COMMA_2 = 2'b01,
    SEL_DATA    = 2'b10
  } comma_length_sel_t;

  // Called only with constant arguments, so it folds to a constant per select.
  function automatic logic [BEATS_W-1:0] beats_for_sel(input logic [1:0] sel, input int nlanes);
    int nbits;
    case (sel)
      SEL_COMMA_1: nbits = SYM_W;
      SEL_COMMA_2: nbits = 2 * SYM_W;
      default:     nbits = FLIT_W;
    endcase
    return BEATS_W'((nbits + nlanes - 1) / nlanes);
  endfunction

endpackage

// File: rtl/phy_tx_serializer.sv
// Lane serializer: captures an encoded flit on start, trims it to the selected
// symbol count and shifts it out NLANES bits per cycle, pulsing done on the last beat.
module phy_tx_serializer
  import phy_types_pkg::*;
#(
  parameter int NLANES = 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              start,
  input  logic [79:0]       enc_flit,
  input  logic [1:0]        comma_length_sel,
  output logic [NLANES-1:0] serial_out,
  output logic              serial_valid,
  output logic              done,
  output logic              busy,
  output logic              overrun,
  output logic              illegal_sel
);

  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

  localparam logic [BEATS_W-1:0] BEATS_C1   = beats_for_sel(SEL_COMMA_1, NLANES);
  localparam logic [BEATS_W-1:0] BEATS_C2   = beats_for_sel(SEL_COMMA_2, NLANES);
  localparam logic [BEATS_W-1:0] BEATS_DATA = beats_for_sel(SEL_DATA, NLANES);
  localparam logic [FLIT_W-1:0]  MASK_C1    = {{(FLIT_W-SYM_W){1'b0}}, {SYM_W{1'b1}}};
  localparam logic [FLIT_W-1:0]  MASK_C2    = {{(FLIT_W-2*SYM_W){1'b0}}, {(2*SYM_W){1'b1}}};

  state_t              state_r, state_s;
  logic [FLIT_W-1:0]   shift_r, shift_s;
  logic [BEATS_W-1:0]  beats_left_r, beats_s;
  logic [NLANES-1:0]   sout_r, sout_s;
  logic                valid_r, valid_s;
  logic                done_r, done_s;
  logic                overrun_r, illegal_r;
  logic                last_s, accept_s;
  logic [BEATS_W-1:0]  sel_beats_s;
  logic [FLIT_W-1:0]   flit_s;

  // Beat count and trim mask for the select on the input; 2'b11 is sent as data.
  always_comb begin
    sel_beats_s = BEATS_DATA;
    flit_s      = enc_flit;
    case (comma_length_sel)
      SEL_COMMA_1: begin
        sel_beats_s = BEATS_C1;
        flit_s      = enc_flit & MASK_C1;
      end
      SEL_COMMA_2: begin
        sel_beats_s = BEATS_C2;
        flit_s      = enc_flit & MASK_C2;
      end
      default: begin
        sel_beats_s = BEATS_DATA;
        flit_s      = enc_flit;
      end
    endcase
  end

  assign last_s   = (state_r == ST_SHIFT) && (beats_left_r == BEATS_W'(1));
  assign accept_s = start && ((state_r == ST_IDLE) || last_s);

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_SHIFT;
        else          state_s = ST_IDLE;
      end
      ST_SHIFT: begin
        if (last_s && !accept_s) state_s = ST_IDLE;
        else                     state_s = ST_SHIFT;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Datapath: the beat presented after the edge is computed here and registered.
  always_comb begin
    shift_s = shift_r;
    beats_s = beats_left_r;
    sout_s  = '0;
    valid_s = 1'b0;
    done_s  = 1'b0;
    if (accept_s) begin
      sout_s  = flit_s[NLANES-1:0];
      shift_s = flit_s >> NLANES;
      beats_s = sel_beats_s;
      valid_s = 1'b1;
      done_s  = (sel_beats_s == BEATS_W'(1));
    end else if ((state_r == ST_SHIFT) && !last_s) begin
      sout_s  = shift_r[NLANES-1:0];
      shift_s = shift_r >> NLANES;
      beats_s = beats_left_r - BEATS_W'(1);
      valid_s = 1'b1;
      done_s  = (beats_left_r == BEATS_W'(2));
    end else begin
      shift_s = '0;
      beats_s = '0;
    end
  end

  // State, shifter and registered outputs; sticky flags clear only on reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r      <= ST_IDLE;
      shift_r      <= '0;
      beats_left_r <= '0;
      sout_r       <= '0;
      valid_r      <= 1'b0;
      done_r       <= 1'b0;
      overrun_r    <= 1'b0;
      illegal_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      shift_r      <= shift_s;
      beats_left_r <= beats_s;
      sout_r       <= sout_s;
      valid_r      <= valid_s;
      done_r       <= done_s;
      overrun_r    <= overrun_r | (start & ~accept_s);
      illegal_r    <= illegal_r | (accept_s & (comma_length_sel == 2'b11));
    end
  end

  assign serial_out   = sout_r;
  assign serial_valid = valid_r;
  assign busy         = valid_r;
  assign done         = done_r;
  assign overrun      = overrun_r;
  assign illegal_sel  = illegal_r;

endmodule
